// File: rtl/module_scope_sched.sv
// rtl/module_scope_sched.sv - round-robin requester scheduler returning a per-requester constant pair
//
// Purpose:
//   Four requesters compete for a single result slot. In IDLE the winner is
//   the first set req bit at or after the round-robin pointer. The winner's
//   id, V1 + id and V2 + id are registered and offered on a valid/ready
//   handshake. Each completed handshake advances the pointer past the winner
//   and is counted in txn_cnt.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req        in   4   request lines, bit i = requester i
//   grant      out  4   one-hot grant of the requester being served, 0 when idle
//   out_valid  out  1   out_id/out1/out2 hold a valid result
//   out_ready  in   1   consumer accepts while out_valid is high
//   out_id     out  2   index of the granted requester
//   out1       out 32   V1 + out_id (mod 2^32)
//   out2       out 32   V2 + out_id (mod 2^32)
//   txn_cnt    out  8   completed handshakes, wraps 255 -> 0

module module_scope_sched #(
   parameter logic [31:0] V1 = 32'd10,
   parameter logic [31:0] V2 = 32'd20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   output logic [3:0]  grant,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_id,
   output logic [31:0] out1,
   output logic [31:0] out2,
   output logic [7:0]  txn_cnt
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  grant_q, grant_d;
   logic        valid_q, valid_d;
   logic [1:0]  id_q, id_d;
   logic [31:0] out1_q, out1_d;
   logic [31:0] out2_q, out2_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        found;
   logic [1:0]  win;
   logic [1:0]  idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         grant_q <= 4'd0;
         valid_q <= 1'b0;
         id_q    <= 2'd0;
         out1_q  <= 32'd0;
         out2_q  <= 32'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      valid_d = valid_q;
      id_d    = id_q;
      out1_d  = out1_q;
      out2_d  = out2_q;
      cnt_d   = cnt_q;
      found   = 1'b0;
      win     = ptr_q;
      idx     = ptr_q;

      // Cyclic search starting at the pointer; the 2-bit index wraps 3 -> 0.
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = 4'b0001 << win;
               id_d    = win;
               out1_d  = V1 + {30'd0, win};
               out2_d  = V2 + {30'd0, win};
               valid_d = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            // Result is frozen here; req is ignored until the consumer takes it.
            if (out_ready) begin
               valid_d = 1'b0;
               grant_d = 4'd0;
               ptr_d   = id_q + 2'd1;
               cnt_d   = cnt_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant     = grant_q;
   assign out_valid = valid_q;
   assign out_id    = id_q;
   assign out1      = out1_q;
   assign out2      = out2_q;
   assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_module_scope_sched.sv
// tb/tb_module_scope_sched.sv - directed self-checking bench for module_scope_sched

module tb_module_scope_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic        out_ready;

   logic [3:0]  grant_a, grant_b, grant_c;
   logic        valid_a, valid_b, valid_c;
   logic [1:0]  id_a, id_b, id_c;
   logic [31:0] o1_a, o1_b, o1_c;
   logic [31:0] o2_a, o2_b, o2_c;
   logic [7:0]  cnt_a, cnt_b, cnt_c;

   int n_checks = 0;
   int n_errors = 0;

   module_scope_sched dut (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_a), .out_valid(valid_a),
      .out_ready(out_ready), .out_id(id_a), .out1(o1_a), .out2(o2_a), .txn_cnt(cnt_a)
   );

   module_scope_sched #(.V1(32'd1), .V2(32'd2)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_b), .out_valid(valid_b),
      .out_ready(out_ready), .out_id(id_b), .out1(o1_b), .out2(o2_b), .txn_cnt(cnt_b)
   );

   module_scope_sched #(.V1(32'hFFFF_FFFF), .V2(32'd20)) dut_c (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_c), .out_valid(valid_c),
      .out_ready(out_ready), .out_id(id_c), .out1(o1_c), .out2(o2_c), .txn_cnt(cnt_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hold reset over one rising edge, release at a falling edge with new inputs.
   task automatic do_reset(input logic [3:0] r, input logic rdy);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      req       = r;
      out_ready = rdy;
   endtask

   initial begin
      logic [1:0] exp_seq [5];
      exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
      exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;

      rst_n     = 1'b0;
      req       = 4'd0;
      out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_grant", 32'(grant_a), 32'd0);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_id",    32'(id_a),    32'd0);
      check("rst_out1",  o1_a,         32'd0);
      check("rst_out2",  o2_a,         32'd0);
      check("rst_cnt",   32'(cnt_a),   32'd0);

      // Single request, ready held: 1-cycle latency then handshake
      @(negedge clk);
      rst_n     = 1'b1;
      req       = 4'b0100;
      out_ready = 1'b1;
      @(negedge clk);
      check("s_grant", 32'(grant_a), 32'b0100);
      check("s_id",    32'(id_a),    32'd2);
      check("s_out1",  o1_a,         32'd12);
      check("s_out2",  o2_a,         32'd22);
      check("s_valid", 32'(valid_a), 32'd1);
      req = 4'd0;
      @(negedge clk);
      check("s_hs_valid", 32'(valid_a), 32'd0);
      check("s_hs_grant", 32'(grant_a), 32'd0);
      check("s_hs_cnt",   32'(cnt_a),   32'd1);

      // out_ready with nothing offered must not count
      repeat (3) @(negedge clk);
      check("idle_ready_cnt", 32'(cnt_a), 32'd1);

      // All requesting: round-robin 0,1,2,3,0 on alternate cycles
      do_reset(4'b1111, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rr_id",    32'(id_a),    32'(exp_seq[i]));
         check("rr_valid", 32'(valid_a), 32'd1);
         @(negedge clk);
         check("rr_bubble", 32'(valid_a), 32'd0);
      end
      check("rr_cnt", 32'(cnt_a), 32'd5);
      req = 4'd0;

      // Stall: id 1 held while req changes, then id 3 follows
      @(negedge clk);
      req       = 4'b0010;
      out_ready = 1'b0;
      @(negedge clk);
      req = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         check("stall_id",    32'(id_a),    32'd1);
         check("stall_out1",  o1_a,         32'd11);
         check("stall_grant", 32'(grant_a), 32'b0010);
         check("stall_valid", 32'(valid_a), 32'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_hs_valid", 32'(valid_a), 32'd0);
      check("stall_hs_cnt",   32'(cnt_a),   32'd6);
      @(negedge clk);
      check("next_id",    32'(id_a),    32'd3);
      check("next_grant", 32'(grant_a), 32'b1000);
      req = 4'd0;
      @(negedge clk);
      check("next_cnt", 32'(cnt_a), 32'd7);

      // Reset pulsed mid-offer: outputs clear without a clock edge
      out_ready = 1'b0;
      req       = 4'b0100;
      @(negedge clk);
      check("pre_rst_valid", 32'(valid_a), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(valid_a), 32'd0);
      check("async_grant", 32'(grant_a), 32'd0);
      check("async_cnt",   32'(cnt_a),   32'd0);
      check("async_id",    32'(id_a),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0011;
      @(negedge clk);
      check("post_rst_id",    32'(id_a),    32'd0);
      check("post_rst_grant", 32'(grant_a), 32'b0001);

      // Parameter variants
      do_reset(4'b1000, 1'b0);
      @(negedge clk);
      check("p1_out1", o1_b, 32'd4);
      check("p1_out2", o2_b, 32'd5);
      do_reset(4'b0010, 1'b0);
      @(negedge clk);
      check("wrap_out1", o1_c, 32'd0);
      check("wrap_out2", o2_c, 32'd21);

      // Counter wrap after 256 handshakes
      do_reset(4'b0001, 1'b1);
      repeat (510) @(negedge clk);
      check("cnt_255", 32'(cnt_a), 32'd255);
      repeat (2) @(negedge clk);
      check("cnt_wrap", 32'(cnt_a), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/module_scope_sched.md
MODULE_SCOPE_SCHED -- requirements
Module: module_scope_sched

Interface
REQ-001 Parameter V1, default 10: 32-bit base value of the first result word.
REQ-002 Parameter V2, default 20: 32-bit base value of the second result word.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port req  input  4: request lines; bit i set means requester i wants its constant pair.
REQ-006 Port grant  output  4: one-hot grant to the requester currently being served; all zero when idle.
REQ-007 Port out_valid  output  1: out_id, out1 and out2 hold a valid result.
REQ-008 Port out_ready  input  1: consumer accepts the result when it is high while out_valid is high.
REQ-009 Port out_id  output  2: index of the granted requester.
REQ-010 Port out1  output  32: first result word, V1 + out_id, modulo 2^32.
REQ-011 Port out2  output  32: second result word, V2 + out_id, modulo 2^32.
REQ-012 Port txn_cnt  output  8: count of completed handshakes, wrapping 255 -> 0.

Function
REQ-013 The FSM SHALL have two states, IDLE and OFFER, held in a registered state variable.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with outputs unchanged and out_valid = 0.
REQ-015 In IDLE with req != 0, the block SHALL pick the winner as the first set req bit at or after ptr, searching cyclically 0..3.
REQ-016 On that same edge it SHALL register grant, out_id, out1 and out2, set out_valid = 1, and enter OFFER.
REQ-017 Request-to-out_valid latency SHALL be exactly 1 cycle.
REQ-018 In OFFER, grant, out_id, out1, out2 and out_valid SHALL hold stable until the handshake, regardless of req changes, including the granted bit dropping.
REQ-019 The handshake SHALL complete on an edge in OFFER with out_ready = 1.
REQ-020 On handshake the block SHALL:
- clear out_valid and grant,
- set ptr = (out_id + 1) mod 4,
- increment txn_cnt,
- return to IDLE.
REQ-021 After each handshake there SHALL be a mandatory one-cycle IDLE bubble, so back-to-back results are at most 1 per 2 cycles.
REQ-022 out_ready while out_valid = 0 SHALL have no effect.
REQ-023 Adders SHALL be 32-bit with the carry discarded; V1 = 32'hFFFFFFFF, out_id = 1 gives out1 = 0.
REQ-024 A requester that holds its req high SHALL wait at most 3 other grants before being served.

Reset
REQ-025 While rst_n = 0, asynchronously and independent of clk, the block SHALL force:
- state = IDLE,
- ptr = 0,
- grant = 0,
- out_valid = 0,
- out_id = 0,
- out1 = 0,
- out2 = 0,
- txn_cnt = 0.
REQ-026 Reset asserted in OFFER SHALL abandon the pending result with no handshake and no txn_cnt increment.
REQ-027 After rst_n deasserts, the first grant SHALL be evaluated on the first rising edge with rst_n = 1.

Verification
REQ-028 Reset, then req = 4'b0100 with out_ready = 1 held -> next cycle grant = 4'b0100, out_id = 2, out1 = 12, out2 = 22, out_valid = 1; next edge out_valid = 0, txn_cnt = 1.
REQ-029 req = 4'b1111 held, out_ready = 1 -> out_id sequence 0, 1, 2, 3, 0, each on alternate cycles; txn_cnt = 5 after 10 cycles.
REQ-030 Grant id 1, out_ready = 0 for 5 cycles, req switched to 4'b1000 -> out_id = 1, out1 = 11 stable for all 5 cycles; on out_ready = 1 handshake, next grant is id 3.
REQ-031 Parameters V1 = 1, V2 = 2, req = 4'b1000 -> out1 = 4, out2 = 5; V1 = 32'hFFFFFFFF, req = 4'b0010 -> out1 = 0.
REQ-032 rst_n pulsed low mid-OFFER -> out_valid = 0, grant = 0 immediately without a clock edge; txn_cnt = 0; after release with req = 4'b0011 the first grant is id 0.
REQ-033 256 handshakes -> txn_cnt wraps to 0.
